register_file: RTL
==================

REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 SHALL have parameter N, default 32: register and data width in bits.
REQ-002 SHALL have parameter DEPTH, default 32: number of architectural registers; address width is $clog2(DEPTH).
REQ-003 SHALL have parameter SP_RESET, default 32'h0000_1000: reset value of register x2.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-006 SHALL have port wr_ena, input, 1: write enable.
REQ-007 SHALL have port wr_addr, input, $clog2(DEPTH): write register index.
REQ-008 SHALL have port wr_data, input, N: write data.
REQ-009 SHALL have port rd_addr0, input, $clog2(DEPTH): read port 0 index (rs1).
REQ-010 SHALL have port rd_data0, output, N: read port 0 data; feeds the ALU shift data input.
REQ-011 SHALL have port rd_addr1, input, $clog2(DEPTH): read port 1 index (rs2).
REQ-012 SHALL have port rd_data1, output, N: read port 1 data; its low $clog2(N) bits feed the ALU shift amount.

Function
REQ-013 SHALL hold DEPTH registers x0..x(DEPTH-1), each N bits.
REQ-014 SHALL hardwire x0 to zero: reads of index 0 return 0, and writes to index 0 are discarded.
REQ-015 SHALL update x[wr_addr] <= wr_data on the rising clk edge when wr_ena=1, rst=0, and wr_addr!=0.
REQ-016 SHALL leave all registers unchanged when wr_ena=0.
REQ-017 SHALL make both read ports combinational (zero latency): rd_dataK = x[rd_addrK] as currently stored.
REQ-018 SHALL provide no write-to-read bypass: a read of the address being written in the same cycle returns the old value; the new value is visible the cycle after the edge.
REQ-019 SHALL let both read ports address the same register simultaneously, each returning identical data.
REQ-020 SHALL treat a rd_data1 value with nonzero bits above [$clog2(N)-1:0] as normal data; the register file does no masking.
REQ-021 SHALL hold exactly one write port; concurrent write and reads never conflict or stall.
REQ-022 SHALL have no internal state other than the register array: no counters, no pending writes.

Reset
REQ-023 SHALL, on any rising clk edge with rst=1, set every register to 0 except x2, which is set to SP_RESET.
REQ-024 SHALL give rst priority over wr_ena: a write presented in a reset cycle is discarded.
REQ-025 SHALL make rd_data0 and rd_data1 reflect reset values combinationally from the cycle after the reset edge (x2 reads SP_RESET; all others read 0).
REQ-026 SHALL allow reset mid-operation: an asserted rst clears all prior writes regardless of history; the first write after rst deasserts takes effect normally.

Verification
REQ-027 SHALL pass the reset check: assert rst for 1 cycle, then read all 32 addresses on both ports -> x2=0x00001000; all others 0x00000000.
REQ-028 SHALL pass the write/read check: write x5=0xDEADBEEF; the same cycle, read rd_addr0=5 -> 0x00000000 (old value); next cycle -> 0xDEADBEEF on both ports when both are addressed to 5.
REQ-029 SHALL pass the x0 check: write x0=0xFFFFFFFF with wr_ena=1, then read x0 on both ports -> 0x00000000.
REQ-030 SHALL pass the shift-operand check: x1=0x80000000 and x3=0x00000024; read rd_addr0=1, rd_addr1=3 -> rd_data0=0x80000000, rd_data1=0x00000024 (low 5 bits = 4).
REQ-031 SHALL pass the reset-priority check: wr_ena=1 writes x7=0x12345678 while rst=1 -> x7 reads 0 afterwards; repeating the write with rst=0 -> x7 reads 0x12345678.
REQ-032 SHALL pass the write-enable check: wr_ena=0 with wr_addr=9 and wr_data=0xAAAAAAAA -> x9 keeps its prior value.

Source files
------------

// File: rtl/register_file.sv
// rtl/register_file.sv - DEPTH x N register file, x0 hardwired to zero, x2 resets to SP_RESET
// Two combinational read ports, one synchronous write port, no write-to-read bypass.
module register_file #(
   parameter int             N        = 32,
   parameter int             DEPTH    = 32,
   parameter logic [N-1:0]   SP_RESET = 32'h0000_1000,
   localparam int            AW       = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_ena,
   input  logic [AW-1:0] wr_addr,
   input  logic [N-1:0]  wr_data,
   input  logic [AW-1:0] rd_addr0,
   output logic [N-1:0]  rd_data0,
   input  logic [AW-1:0] rd_addr1,
   output logic [N-1:0]  rd_data1
);

   logic [N-1:0] regs_q [DEPTH];
   logic [N-1:0] regs_d [DEPTH];

   always_comb begin
      regs_d = regs_q;
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = (i == 2) ? SP_RESET : '0;
         end
      end else if (wr_ena && (wr_addr != '0)) begin
         regs_d[wr_addr] = wr_data;
      end
      // x0 is kept at zero so reads of index 0 never need a special case.
      regs_d[0] = '0;
   end

   always_ff @(posedge clk) begin
      regs_q <= regs_d;
   end

   assign rd_data0 = regs_q[rd_addr0];
   assign rd_data1 = regs_q[rd_addr1];

endmodule
